// File: rtl/sc_dmem_arbiter.sv
// rtl/sc_dmem_arbiter.sv - two-master arbiter for the shared data-memory/IO bus
//
// Purpose:
//   Shares one data-memory/IO bus between m0 (CPU load/store port) and m1
//   (DMA/debug loader). A request is latched in IDLE, issued on the bus for one
//   cycle, held for ACCESS_LAT cycles, then completed with a one-cycle ack.
//   FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//
// Ports:
//   clock, reset                   system clock, synchronous active-high reset
//   m0_req/we/addr/wdata           master 0 request (held until m0_ack)
//   m0_gnt, m0_ack, m0_rdata       master 0 grant, completion pulse, read data
//   m1_*                           identical set for master 1
//   mem_addr, mem_datain, mem_we   shared bus outputs
//   mem_dataout                    shared bus read data
//   busy                           high whenever the FSM is not in IDLE
//
// Configuration:
//   SC_DMEM_ARB_FIXED_PRIO_EN  defined: m0 always wins ties (CPU priority)
//                              undefined: round-robin on ties

module sc_dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ACCESS_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              busy
);

  generate
    if (ACCESS_LAT < 1 || ACCESS_LAT > 15) begin : g_bad_access_lat
      $error("sc_dmem_arbiter: ACCESS_LAT must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] LAT_M1 = 4'(ACCESS_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state;
  logic       sel_m1;     // owner of the current transaction
  logic       we_q;       // latched write flag of the current transaction
  logic       last_m1;    // last-served pointer, 1 = m1 served last
  logic [3:0] lat_cnt;
  logic       pick_m1;

  // Winner selection, only consumed in IDLE.
  always_comb begin
    pick_m1 = 1'b0;
    if (m1_req && !m0_req) begin
      pick_m1 = 1'b1;
    end else if (m0_req && m1_req) begin
`ifdef SC_DMEM_ARB_FIXED_PRIO_EN
      pick_m1 = 1'b0;
`else
      pick_m1 = !last_m1;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel_m1     <= 1'b0;
      we_q       <= 1'b0;
      last_m1    <= 1'b1;
      lat_cnt    <= 4'd0;
      mem_addr   <= '0;
      mem_datain <= '0;
      mem_we     <= 1'b0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            sel_m1     <= pick_m1;
            we_q       <= pick_m1 ? m1_we : m0_we;
            mem_addr   <= pick_m1 ? m1_addr : m0_addr;
            mem_datain <= pick_m1 ? m1_wdata : m0_wdata;
            // Write strobe is visible exactly during the ISSUE cycle.
            mem_we     <= pick_m1 ? m1_we : m0_we;
            m0_gnt     <= !pick_m1;
            m1_gnt     <= pick_m1;
            busy       <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_we  <= 1'b0;
          lat_cnt <= LAT_M1;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt == 4'd0) begin
            if (!we_q) begin
              if (sel_m1) m1_rdata <= mem_dataout;
              else        m0_rdata <= mem_dataout;
            end
            m0_ack <= !sel_m1;
            m1_ack <= sel_m1;
            state  <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
          m0_gnt  <= 1'b0;
          m1_gnt  <= 1'b0;
          busy    <= 1'b0;
          last_m1 <= sel_m1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
